// File: rtl/clock_mux_pkg.sv
// Shared types and default parameters for the clock mux sequencer and its
// per-source activity monitor.
package clock_mux_pkg;

  localparam int DEF_NUM_CLOCKS    = 3;
  localparam int DEF_WINDOW        = 1024;
  localparam int DEF_MIN_EDGES     = 4;
  localparam int DEF_DRAIN_CYCLES  = 16;
  localparam int DEF_SETTLE_CYCLES = 16;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_DRAIN,
    ST_CHECK,
    ST_SETTLE,
    ST_RUN,
    ST_FAIL
  } state_e;

endpackage

// File: rtl/clock_activity_monitor.sv
// Per-source liveness detector: synchronizes each divided-down source toggle,
// counts its edges over a shared window and latches an alive verdict per window.
module clock_activity_monitor
  import clock_mux_pkg::*;
#(
  parameter int NUM_CLOCKS = DEF_NUM_CLOCKS,
  parameter int WINDOW     = DEF_WINDOW,
  parameter int MIN_EDGES  = DEF_MIN_EDGES
) (
  input  logic                  clk,
  input  logic                  reset_n,
  input  logic [NUM_CLOCKS-1:0] clk_toggle,
  output logic [NUM_CLOCKS-1:0] clk_alive
);

  localparam int WIN_W  = $clog2(WINDOW);
  localparam int EDGE_W = $clog2(MIN_EDGES + 1);

  logic [NUM_CLOCKS-1:0] meta_q, meta_d;
  logic [NUM_CLOCKS-1:0] sync_q, sync_d;
  logic [NUM_CLOCKS-1:0] prev_q, prev_d;
  logic [NUM_CLOCKS-1:0] alive_q, alive_d;
  logic [NUM_CLOCKS-1:0] edge_det;
  logic [WIN_W-1:0]      win_q, win_d;
  logic [EDGE_W-1:0]     cnt_q [NUM_CLOCKS];
  logic [EDGE_W-1:0]     cnt_d [NUM_CLOCKS];
  logic                  win_last;

  always_comb begin
    meta_d   = clk_toggle;
    sync_d   = meta_q;
    prev_d   = sync_q;
    edge_det = sync_q ^ prev_q;
    win_last = (win_q == WIN_W'(WINDOW - 1));
    win_d    = win_last ? '0 : win_q + WIN_W'(1);
    alive_d  = alive_q;
    for (int i = 0; i < NUM_CLOCKS; i++) begin
      cnt_d[i] = cnt_q[i];
      if (win_last) begin
        // An edge landing on the closing cycle seeds the next window.
        alive_d[i] = (cnt_q[i] == EDGE_W'(MIN_EDGES));
        cnt_d[i]   = EDGE_W'(edge_det[i]);
      end else if (edge_det[i] && (cnt_q[i] != EDGE_W'(MIN_EDGES))) begin
        cnt_d[i] = cnt_q[i] + EDGE_W'(1);
      end
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      meta_q  <= '0;
      sync_q  <= '0;
      prev_q  <= '0;
      alive_q <= '0;
      win_q   <= '0;
      for (int i = 0; i < NUM_CLOCKS; i++) cnt_q[i] <= '0;
    end else begin
      meta_q  <= meta_d;
      sync_q  <= sync_d;
      prev_q  <= prev_d;
      alive_q <= alive_d;
      win_q   <= win_d;
      cnt_q   <= cnt_d;
    end
  end

  assign clk_alive = alive_q;

endmodule

// File: rtl/clock_mux_ctrl.sv
// Sequencer for the glitch-free clock mux select: drains the old source,
// verifies the new one is running, settles, and drops a source that dies.
module clock_mux_ctrl
  import clock_mux_pkg::*;
#(
  parameter int NUM_CLOCKS    = DEF_NUM_CLOCKS,
  parameter int WINDOW        = DEF_WINDOW,
  parameter int MIN_EDGES     = DEF_MIN_EDGES,
  parameter int DRAIN_CYCLES  = DEF_DRAIN_CYCLES,
  parameter int SETTLE_CYCLES = DEF_SETTLE_CYCLES
) (
  input  logic                  clk,
  input  logic                  reset_n,
  input  logic [NUM_CLOCKS-1:0] clk_toggle,
  input  logic                  req_valid,
  input  logic [NUM_CLOCKS-1:0] req_sel,
  output logic [NUM_CLOCKS-1:0] clk_select,
  output logic [NUM_CLOCKS-1:0] clk_alive,
  output logic                  busy,
  output logic                  ready,
  output logic                  error
);

  localparam int CNT_MAX = (DRAIN_CYCLES > SETTLE_CYCLES) ? DRAIN_CYCLES : SETTLE_CYCLES;
  localparam int CNT_W   = (CNT_MAX > 1) ? $clog2(CNT_MAX) : 1;

  state_e                state_q, state_d;
  logic [NUM_CLOCKS-1:0] target_q, target_d;
  logic [NUM_CLOCKS-1:0] sel_q, sel_d;
  logic [CNT_W-1:0]      cnt_q, cnt_d;
  logic                  busy_q, busy_d;
  logic                  ready_q, ready_d;
  logic                  error_q, error_d;
  logic                  multi_hot, target_alive, take_req, reject;

  clock_activity_monitor #(
    .NUM_CLOCKS (NUM_CLOCKS),
    .WINDOW     (WINDOW),
    .MIN_EDGES  (MIN_EDGES)
  ) u_monitor (
    .clk        (clk),
    .reset_n    (reset_n),
    .clk_toggle (clk_toggle),
    .clk_alive  (clk_alive)
  );

  always_comb begin
    state_d      = state_q;
    target_d     = target_q;
    cnt_d        = cnt_q;
    reject       = 1'b0;
    multi_hot    = ((req_sel & (req_sel - NUM_CLOCKS'(1))) != '0);
    target_alive = |(clk_alive & target_q);
    // A dying source in RUN takes precedence over any request that cycle.
    take_req     = req_valid && ((state_q == ST_IDLE) || (state_q == ST_FAIL) ||
                                 ((state_q == ST_RUN) && target_alive));

    if (take_req) begin
      if (multi_hot) begin
        reject = 1'b1;
      end else if (!((state_q == ST_RUN) && (req_sel == target_q))) begin
        target_d = req_sel;
        cnt_d    = '0;
        state_d  = ST_DRAIN;
      end
    end

    case (state_q)
      ST_DRAIN: begin
        if (cnt_q == CNT_W'(DRAIN_CYCLES - 1)) begin
          cnt_d   = '0;
          state_d = (target_q == '0) ? ST_IDLE : ST_CHECK;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      ST_CHECK:  state_d = target_alive ? ST_SETTLE : ST_FAIL;
      ST_SETTLE: begin
        if (cnt_q == CNT_W'(SETTLE_CYCLES - 1)) begin
          cnt_d   = '0;
          state_d = ST_RUN;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      ST_RUN:    if (!target_alive) state_d = ST_FAIL;
      default:   ;
    endcase

    // Outputs are registered from the next state so the mux select never glitches.
    sel_d   = ((state_d == ST_SETTLE) || (state_d == ST_RUN)) ? target_d : '0;
    busy_d  = (state_d == ST_DRAIN) || (state_d == ST_CHECK) || (state_d == ST_SETTLE);
    ready_d = (state_d == ST_RUN);
    error_d = (state_d == ST_FAIL) || reject;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q  <= ST_IDLE;
      target_q <= '0;
      sel_q    <= '0;
      cnt_q    <= '0;
      busy_q   <= 1'b0;
      ready_q  <= 1'b0;
      error_q  <= 1'b0;
    end else begin
      state_q  <= state_d;
      target_q <= target_d;
      sel_q    <= sel_d;
      cnt_q    <= cnt_d;
      busy_q   <= busy_d;
      ready_q  <= ready_d;
      error_q  <= error_d;
    end
  end

  assign clk_select = sel_q;
  assign busy       = busy_q;
  assign ready      = ready_q;
  assign error      = error_q;

endmodule

// File: doc/clock_mux_ctrl.md
# clock_mux_ctrl

Single-clock sequencer that drives the one-hot `clk_select` of the glitch-free clock mux, so switching between RGMII/GMII clock sources on a speed change is safe. It monitors activity of every candidate clock, holds all selects low while the old clock drains out of the mux, and selects the target only if that clock is verifiably running. It also deselects a clock that dies, because the mux sticks when the running source stops. Sits in the system clock domain beside the PHY speed/link logic.

## Interface
- `NUM_CLOCKS`, 3: number of candidate clocks; must match the mux.
- `WINDOW`, 1024: activity-measurement window in `clk` cycles, minimum 16.
- `MIN_EDGES`, 4: synchronized toggle edges per window required for "alive".
- `DRAIN_CYCLES`, 16: cycles all selects are held low before a new select.
- `SETTLE_CYCLES`, 16: cycles after the new select before `ready` asserts.
- `clk` in 1: system clock; all logic is on its rising edge.
- `reset_n` in 1: asynchronous assert, active-low reset.
- `clk_toggle` in NUM_CLOCKS: per-source divided-by-8 square wave, generated in each source domain; asynchronous to `clk`.
- `req_valid` in 1: one-cycle request strobe.
- `req_sel` in NUM_CLOCKS: requested source, one-hot; all-zero means deselect all.
- `clk_select` out NUM_CLOCKS: one-hot or zero; connects to the mux.
- `clk_alive` out NUM_CLOCKS: per-source activity verdict from the last completed window.
- `busy` out 1: high in DRAIN, CHECK and SETTLE; requests are ignored while high.
- `ready` out 1: high in RUN only.
- `error` out 1: last request failed or the running clock died; cleared by the next accepted request.

## Operation
- **Reset:** all outputs 0; state IDLE; all counters 0.
- **Activity monitor, per bit:**
  - 2-flop synchronizer, then edge detect (synchronized value XOR its previous value).
  - Edge counter saturates at MIN_EDGES.
  - A shared window counter runs 0..WINDOW-1. At the last cycle, `clk_alive[i] <= (cnt[i] == MIN_EDGES)` and all edge counters clear.
  - An edge in that same last cycle counts toward the next window.
- **States:** IDLE, DRAIN, CHECK, SETTLE, RUN, FAIL.
- **Accepting requests:** only in IDLE, RUN or FAIL.
  - Multi-hot `req_sel`: rejected. `error` pulses high for one cycle; state and `clk_select` are unchanged.
  - `req_sel` equal to the current `clk_select` while in RUN: no-op.
  - Any other valid request: latch the target, clear `error`, go to DRAIN.
- **DRAIN:** `clk_select` = 0 and a counter runs DRAIN_CYCLES. Then go to IDLE if the target is zero, otherwise to CHECK.
- **CHECK:** one cycle.
  - `clk_alive[target]` = 1: go to SETTLE, `clk_select` = target.
  - Otherwise: go to FAIL, `error` = 1, `clk_select` stays 0.
- **SETTLE:** counts SETTLE_CYCLES, then go to RUN.
- **RUN:** if `clk_alive[target]` falls, in the next cycle `clk_select` = 0, `ready` = 0, `error` = 1, state FAIL.
- **FAIL:** no automatic retry; it waits for a new request.
- `req_valid` while `busy` is dropped silently and is not queued.

## Timing
- Accepted request at edge T:
  - `busy` = 1 and `clk_select` = 0 from T+1.
  - CHECK at T+1+DRAIN_CYCLES.
  - `clk_select` = target from T+2+DRAIN_CYCLES.
  - `ready` = 1 and `busy` = 0 from T+2+DRAIN_CYCLES+SETTLE_CYCLES.
- A deselect request (all-zero) returns to IDLE with `busy` = 0 at T+1+DRAIN_CYCLES.
- `clk_alive` latency: up to 2×WINDOW + 2 cycles after a source starts or stops.
- `clk_select` never changes directly from one nonzero value to another; there is always at least DRAIN_CYCLES of zero in between.
- Counters sized $clog2 of their parameter; DRAIN/SETTLE counters count from 0 to N-1.
- `reset_n` asserted mid-sequence: outputs zero immediately (asynchronous).

## Structure
- Shared package `clock_mux_pkg`: state enum, default parameter constants.
- Sub-module `clock_activity_monitor`: synchronizers, edge counters, window counter; parameters NUM_CLOCKS, WINDOW, MIN_EDGES; output `clk_alive`.
- Top level: FSM, drain/settle counter, request latch.

## Test plan
Bench parameters: NUM_CLOCKS=3, WINDOW=64, MIN_EDGES=4, DRAIN=4, SETTLE=4.
- **Basic select:** sources 0 and 1 toggle, 2 idle. After 2 windows, request 3'b001 at T → `clk_select` = 3'b001 at T+6, `ready` at T+10, `clk_alive` = 3'b011.
- **Switch:** from RUN(3'b001), request 3'b010 at T → `clk_select` = 0 for T+1..T+5, 3'b010 at T+6, never both bits set.
- **Dead target:** request 3'b100 → FAIL, `error` = 1, `clk_select` = 0. A later request 3'b001 clears `error` and reaches RUN.
- **Clock loss:** source 1 stops while in RUN(3'b010) → within 2×64+3 cycles `clk_select` = 0, `error` = 1, `ready` = 0.
- **Rejected and ignored requests:** 3'b011 in RUN → one-cycle `error` pulse, selection unchanged. `req_valid` during DRAIN → ignored.
- **Reset mid-operation:** assert `reset_n` low during SETTLE → all outputs 0 asynchronously; after release, state is IDLE and `clk_alive` is 0 until the first window completes.
